bc_polinomio: RTL and testbench

- Control unit (bloco de controle) for the polynomial datapath (BO).
- Sequences mux selects, register loads and the ULA operation so that BO evaluates y = (A*x + B)*x + C by Horner's rule, leaving y in R2.
- Sits directly upstream of BO and drives every control input of BO.
- Moore FSM with a per-step wait counter that covers the clocked ULA latency.

---
 rtl/bc_polinomio.sv | 127 ++++++++++++
 tb/tb_bc_polinomio.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_polinomio.sv
// Control unit for the Horner polynomial datapath: sequences selects, loads and
// the ULA operation so that R2 ends up holding y = (A*x + B)*x + C.
module bc_polinomio #(
    parameter int unsigned ULA_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iniciar,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       LX,
    output logic       LH,
    output logic       LS,
    output logic       H,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        MUL_A   = 3'd2,
        SOMA_B  = 3'd3,
        MUL_X   = 3'd4,
        SOMA_C  = 3'd5,
        PRONTO  = 3'd6
    } estado_t;

    localparam logic [2:0] LAT = 3'(ULA_LAT);

    estado_t    estado_q, estado_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] m0_q, m0_d, m1_q, m1_d, m2_q, m2_d;
    logic       lx_q, lx_d, lh_q, lh_d, ls_q, ls_d, h_q, h_d;
    logic       ocupado_q, ocupado_d, pronto_q, pronto_d;
    logic       op_last, load_d;

    // Next state; the counter restarts at 0 whenever an op state is entered.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = '0;
        op_last  = (cnt_q == LAT);
        case (estado_q)
            OCIOSO:  if (iniciar) estado_d = CARREGA;
            CARREGA: estado_d = MUL_A;
            MUL_A:   if (op_last) estado_d = SOMA_B; else cnt_d = cnt_q + 3'd1;
            SOMA_B:  if (op_last) estado_d = MUL_X;  else cnt_d = cnt_q + 3'd1;
            MUL_X:   if (op_last) estado_d = SOMA_C; else cnt_d = cnt_q + 3'd1;
            SOMA_C:  if (op_last) estado_d = PRONTO; else cnt_d = cnt_q + 3'd1;
            PRONTO:  estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        m0_d      = 2'b00;
        m1_d      = 2'b00;
        m2_d      = 2'b00;
        lx_d      = 1'b0;
        lh_d      = 1'b0;
        ls_d      = 1'b0;
        h_d       = 1'b0;
        pronto_d  = 1'b0;
        ocupado_d = (estado_d != OCIOSO);
        load_d    = (cnt_d == LAT);
        case (estado_d)
            CARREGA: lx_d = 1'b1;
            MUL_A: begin
                m0_d = 2'b01; h_d = 1'b1; lh_d = load_d;
            end
            SOMA_B: begin
                m0_d = 2'b10; m1_d = 2'b10; m2_d = 2'b01; lh_d = load_d;
            end
            MUL_X: begin
                m1_d = 2'b10; h_d = 1'b1; lh_d = load_d;
            end
            SOMA_C: begin
                m0_d = 2'b11; m1_d = 2'b10; m2_d = 2'b01; ls_d = load_d;
            end
            PRONTO:  pronto_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q  <= OCIOSO;
            cnt_q     <= '0;
            m0_q      <= '0;
            m1_q      <= '0;
            m2_q      <= '0;
            lx_q      <= 1'b0;
            lh_q      <= 1'b0;
            ls_q      <= 1'b0;
            h_q       <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            m0_q      <= m0_d;
            m1_q      <= m1_d;
            m2_q      <= m2_d;
            lx_q      <= lx_d;
            lh_q      <= lh_d;
            ls_q      <= ls_d;
            h_q       <= h_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign M0      = m0_q;
    assign M1      = m1_q;
    assign M2      = m2_q;
    assign LX      = lx_q;
    assign LH      = lh_q;
    assign LS      = ls_q;
    assign H       = h_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;
    assign estado  = estado_q;

endmodule

// File: tb/tb_bc_polinomio.sv
// Bench for bc_polinomio: three instances (ULA_LAT 0, 1, 3) checked every cycle
// against a step-offset model, plus a small datapath model on the ULA_LAT=1 one.
module tb_bc_polinomio;

    localparam int NI = 3;

    function automatic int latof(input int g);
        return (g == 0) ? 0 : (g == 1) ? 1 : 3;
    endfunction

    function automatic int plen(input int g);
        return 2 + 4 * (latof(g) + 1);
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iniciar = 1'b0;

    logic [1:0] m0 [NI];
    logic [1:0] m1 [NI];
    logic [1:0] m2 [NI];
    logic       lx [NI];
    logic       lh [NI];
    logic       ls [NI];
    logic       h  [NI];
    logic       oc [NI];
    logic       pr [NI];
    logic [2:0] est [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bc_polinomio #(.ULA_LAT((g == 0) ? 0 : (g == 1) ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst), .iniciar(iniciar),
            .M0(m0[g]), .M1(m1[g]), .M2(m2[g]),
            .LX(lx[g]), .LH(lh[g]), .LS(ls[g]), .H(h[g]),
            .ocupado(oc[g]), .pronto(pr[g]), .estado(est[g])
        );
    end

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Model: k = cycles since the edge that accepted iniciar (0 = idle).
    int k [NI];
    always @(posedge clk or negedge rst) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst) k[g] <= 0;
            else if (k[g] == 0) k[g] <= iniciar ? 1 : 0;
            else k[g] <= (k[g] == plen(g)) ? 0 : k[g] + 1;
        end
    end

    // {estado, M0, M1, M2, LX, LH, LS, H, ocupado, pronto}
    function automatic logic [14:0] exp_out(input int kk, input int lat);
        logic [2:0] e; logic [1:0] a, b, c;
        logic xl, hl, sl, hh, o, p;
        int op, pos, pl;
        e = 0; a = 0; b = 0; c = 0; xl = 0; hl = 0; sl = 0; hh = 0; o = 0; p = 0;
        pl = 2 + 4 * (lat + 1);
        if (kk != 0) begin
            o = 1;
            if (kk == 1) begin e = 1; xl = 1; end
            else if (kk == pl) begin e = 6; p = 1; end
            else begin
                op  = (kk - 2) / (lat + 1);
                pos = (kk - 2) % (lat + 1);
                e   = 3'(2 + op);
                case (op)
                    0: begin a = 1; hh = 1; hl = (pos == lat); end
                    1: begin a = 2; b = 2; c = 1; hl = (pos == lat); end
                    2: begin b = 2; hh = 1; hl = (pos == lat); end
                    default: begin a = 3; b = 2; c = 1; sl = (pos == lat); end
                endcase
            end
        end
        return {e, a, b, c, xl, hl, sl, hh, o, p};
    endfunction

    // Per-cycle compare plus structural invariants.
    logic [6:0] prev_sel [NI];
    logic       prev_pr  [NI];
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < NI; g++) begin
            logic [14:0] got, ex;
            got = {est[g], m0[g], m1[g], m2[g], lx[g], lh[g], ls[g], h[g], oc[g], pr[g]};
            ex  = exp_out(k[g], latof(g));
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL outs[%0d] cyc=%0d: got %h expected %h", g, cyc, got, ex);
            end
            checks++;
            if (32'(lx[g]) + 32'(lh[g]) + 32'(ls[g]) > 1) begin
                errors++;
                $display("FAIL loads_onehot[%0d] cyc=%0d: got %b%b%b expected at most one", g, cyc, lx[g], lh[g], ls[g]);
            end
            if (latof(g) > 0 && (lh[g] || ls[g])) begin
                checks++;
                if ({m0[g], m1[g], m2[g], h[g]} !== prev_sel[g]) begin
                    errors++;
                    $display("FAIL sel_stable[%0d] cyc=%0d: got %h expected %h", g, cyc, {m0[g], m1[g], m2[g], h[g]}, prev_sel[g]);
                end
            end
            checks++;
            if (pr[g] && prev_pr[g]) begin
                errors++;
                $display("FAIL pronto_pulse[%0d] cyc=%0d: got 2 consecutive expected 1", g, cyc);
            end
            prev_sel[g] = {m0[g], m1[g], m2[g], h[g]};
            prev_pr[g]  = pr[g];
        end
    end

    // Datapath model driven by the ULA_LAT=1 instance.
    logic [15:0] ra, rb, rc, rx, r0, r1, r2, mux0, op1, op2, ula;
    always_comb begin
        mux0 = 16'd0;
        case (m0[1]) 2'b01: mux0 = ra; 2'b10: mux0 = rb; 2'b11: mux0 = rc; default: ; endcase
        op1 = mux0;
        case (m1[1]) 2'b01: op1 = r0; 2'b10: op1 = r1; 2'b11: op1 = r2; default: ; endcase
        op2 = r0;
        case (m2[1]) 2'b01: op2 = mux0; 2'b10: op2 = r1; 2'b11: op2 = r2; default: ; endcase
        ula = h[1] ? 16'(op1 * op2) : 16'(op1 + op2);
    end
    always @(posedge clk) begin
        if (lx[1]) r0 <= rx;
        if (lh[1]) r1 <= ula;
        if (ls[1]) r2 <= ula;
    end

    int lg_est [1:24];
    logic lg_lx [NI][1:24];
    logic lg_lh [NI][1:24];
    logic lg_ls [NI][1:24];
    logic lg_pr [NI][1:24];
    logic lg_oc [1:24];
    int r2_pronto;

    // One run from idle; iniciar optionally toggled randomly while busy.
    task automatic run_once(input bit rnd);
        @(negedge clk) iniciar = 1'b1;
        @(posedge clk);
        r2_pronto = -1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            iniciar = (rnd && c <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            lg_est[c] = int'(est[1]);
            lg_oc[c]  = oc[1];
            for (int g = 0; g < NI; g++) begin
                lg_lx[g][c] = lx[g]; lg_lh[g][c] = lh[g];
                lg_ls[g][c] = ls[g]; lg_pr[g][c] = pr[g];
            end
            if (pr[1]) r2_pronto = int'(r2);
        end
    endtask

    function automatic int first_pr(input int g);
        for (int c = 1; c <= 24; c++) if (lg_pr[g][c]) return c;
        return -1;
    endfunction

    task automatic check_lat1_run(input string tag);
        int exp_est [1:11];
        exp_est = '{1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 0};
        for (int c = 1; c <= 11; c++) chk($sformatf("%s estado c%0d", tag, c), lg_est[c], exp_est[c]);
        for (int c = 1; c <= 11; c++) begin
            chk($sformatf("%s LX c%0d", tag, c), int'(lg_lx[1][c]), (c == 1) ? 1 : 0);
            chk($sformatf("%s LH c%0d", tag, c), int'(lg_lh[1][c]), (c == 3 || c == 5 || c == 7) ? 1 : 0);
            chk($sformatf("%s LS c%0d", tag, c), int'(lg_ls[1][c]), (c == 9) ? 1 : 0);
            chk($sformatf("%s ocupado c%0d", tag, c), int'(lg_oc[c]), (c <= 10) ? 1 : 0);
        end
        chk($sformatf("%s pronto lat1", tag), first_pr(1), 10);
    endtask

    initial begin
        int pts [$];
        int found;
        rx = 0; ra = 0; rb = 0; rc = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset estado", int'(est[1]), 0);
        chk("reset ocupado", int'(oc[1]), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single run, A=2 B=3 C=4 x=5
        ra = 16'd2; rb = 16'd3; rc = 16'd4; rx = 16'd5;
        run_once(1'b0);
        check_lat1_run("run1");
        chk("run1 R2", r2_pronto, 69);
        chk("lat0 pronto", first_pr(0), 6);
        for (int c = 2; c <= 5; c++) chk($sformatf("lat0 load c%0d", c), int'(lg_lh[0][c] | lg_ls[0][c]), 1);
        chk("lat0 LS c5", int'(lg_ls[0][5]), 1);
        chk("lat3 pronto", first_pr(2), 18);

        // Wide operands, modulo 2^16
        ra = 16'd300; rb = 16'd7; rc = 16'd1; rx = 16'd300;
        run_once(1'b0);
        chk("run2 R2", r2_pronto, 1269);

        // iniciar toggled while busy: lat1 timing unchanged
        run_once(1'b1);
        check_lat1_run("rnd");
        repeat (25) @(negedge clk);

        // Held high: back-to-back runs
        iniciar = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pr[1]) pts.push_back(cyc);
        end
        iniciar = 1'b0;
        chk("held pronto count", pts.size(), 3);
        for (int i = 1; i < pts.size(); i++) chk($sformatf("held spacing %0d", i), pts[i] - pts[i-1], 11);
        repeat (25) @(negedge clk);

        // Reset mid-sequence in MUL_X
        @(negedge clk) iniciar = 1'b1;
        @(negedge clk) iniciar = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(posedge clk);
            #1;
            if (est[1] == 3'd4) found = 1;
        end
        chk("reach MUL_X", found, 1);
        #1 rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("midrst outs[%0d]", g),
                int'({est[g], m0[g], m1[g], m2[g], lx[g], lh[g], ls[g], h[g], oc[g], pr[g]}), 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle after reset", int'(est[1]), 0);

        // Random runs
        for (int c = 0; c < 14000; c++) begin
            @(negedge clk);
            iniciar = ($urandom_range(0, 3) == 0);
        end
        iniciar = 1'b0;
        repeat (25) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
